// File: rtl/buf_rd_arbiter_if.sv
// rtl/buf_rd_arbiter_if.sv - requester and ultrasonic-buffer signals of the read arbiter
interface buf_rd_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 25
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [NUM_REQ-1:0] err;
  logic [DATA_W-1:0]  rd_data;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               buf_read_request;
  logic               buf_data_valid;
  logic [DATA_W-1:0]  buf_data_in;
  logic [15:0]        timeout_cnt;

  modport master (
    input  req, buf_data_valid, buf_data_in,
    output ack, err, rd_data, grant_id, busy, buf_read_request, timeout_cnt
  );

  modport slave (
    output req, buf_data_valid, buf_data_in,
    input  ack, err, rd_data, grant_id, busy, buf_read_request, timeout_cnt
  );
endinterface

// File: rtl/buf_rd_arbiter.sv
// rtl/buf_rd_arbiter.sv - round-robin arbiter sharing one ultrasonic buffer read port
module buf_rd_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 25,
  parameter int TIMEOUT = 16,
  parameter int GAP     = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  buf_rd_arbiter_if.master  bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [NUM_REQ-1:0] ack_q, ack_n;
  logic [NUM_REQ-1:0] err_q, err_n;
  logic [DATA_W-1:0]  rd_q, rd_n;
  logic [ID_W-1:0]    gid_q, gid_n;
  logic [ID_W-1:0]    last_q, last_n;
  logic               brr_q, brr_n;
  logic               busy_q, busy_n;
  logic [15:0]        tcnt_q, tcnt_n;
  logic               prev_valid;
  logic               rise;
  logic [ID_W-1:0]    winner;

  // First set request strictly after the last grant, wrapping around.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_W-1:0] last);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;
    int              c;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c   = (int'(last) + i) % NUM_REQ;
      idx = c[ID_W-1:0];
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign winner = rr_pick(bus.req, last_q);
  assign rise   = bus.buf_data_valid & ~prev_valid;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ack_n   = '0;
    err_n   = '0;
    rd_n    = rd_q;
    gid_n   = gid_q;
    last_n  = last_q;
    brr_n   = brr_q;
    tcnt_n  = tcnt_q;
    case (state)
      ST_IDLE: begin
        if (|bus.req) begin
          state_n = ST_REQ;
          brr_n   = 1'b1;
          gid_n   = winner;
          cnt_n   = '0;
        end
      end
      ST_REQ: begin
        // A rising edge on the last wait cycle still counts as data.
        if (rise) begin
          rd_n    = bus.buf_data_in;
          ack_n   = ONE_HOT0 << gid_q;
          brr_n   = 1'b0;
          last_n  = gid_q;
          cnt_n   = '0;
          state_n = ST_GAP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_n   = ONE_HOT0 << gid_q;
          brr_n   = 1'b0;
          last_n  = gid_q;
          cnt_n   = '0;
          state_n = ST_GAP;
          if (tcnt_q != 16'hFFFF) begin
            tcnt_n = tcnt_q + 16'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt == CW'(GAP - 1)) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        brr_n   = 1'b0;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      rd_q       <= '0;
      gid_q      <= '0;
      last_q     <= ID_W'(NUM_REQ - 1);
      brr_q      <= 1'b0;
      busy_q     <= 1'b0;
      tcnt_q     <= '0;
      prev_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ack_q      <= ack_n;
      err_q      <= err_n;
      rd_q       <= rd_n;
      gid_q      <= gid_n;
      last_q     <= last_n;
      brr_q      <= brr_n;
      busy_q     <= busy_n;
      tcnt_q     <= tcnt_n;
      prev_valid <= bus.buf_data_valid;
    end
  end

  assign bus.ack              = ack_q;
  assign bus.err              = err_q;
  assign bus.rd_data          = rd_q;
  assign bus.grant_id         = gid_q;
  assign bus.busy             = busy_q;
  assign bus.buf_read_request = brr_q;
  assign bus.timeout_cnt      = tcnt_q;
endmodule

// File: tb/tb_buf_rd_arbiter.sv
// tb/tb_buf_rd_arbiter.sv - randomized transaction-level check of buf_rd_arbiter
module tb_buf_rd_arbiter;
  localparam int NR = 3;
  localparam int DW = 25;
  localparam int TO = 16;
  localparam int GP = 2;
  localparam int IW = 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  buf_rd_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus();

  buf_rd_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO), .GAP(GP)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [NR-1:0] e_ack, e_err;
  logic [DW-1:0] e_rd;
  logic [IW-1:0] e_gid;
  logic          e_busy, e_brr;
  logic [15:0]   e_tcnt;

  int            m_last, m_grant;
  logic [DW-1:0] m_rd;
  logic [15:0]   m_tcnt;

  logic          prev_brr = 1'b0;
  int            t_brr, t_ack, t_err, t_req, n_ack, n_err;
  logic [NR-1:0] last_ack;
  int            glog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  task automatic compare_cycle();
    check("ack", 32'(bus.ack), 32'(e_ack));
    check("err", 32'(bus.err), 32'(e_err));
    check("rd_data", 32'(bus.rd_data), 32'(e_rd));
    check("grant_id", 32'(bus.grant_id), 32'(e_gid));
    check("busy", 32'(bus.busy), 32'(e_busy));
    check("buf_read_request", 32'(bus.buf_read_request), 32'(e_brr));
    check("timeout_cnt", 32'(bus.timeout_cnt), 32'(e_tcnt));
    if (bus.buf_read_request && !prev_brr) t_brr = cyc;
    prev_brr = bus.buf_read_request;
    if (|bus.ack) begin t_ack = cyc; n_ack++; last_ack = bus.ack; glog.push_back(int'(bus.grant_id)); end
    if (|bus.err) begin t_err = cyc; n_err++; glog.push_back(int'(bus.grant_id)); end
  endtask

  task automatic step();
    @(negedge aclk);
    compare_cycle();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    m_last = NR - 1; m_grant = 0; m_rd = '0; m_tcnt = '0;
  endtask

  task automatic set_idle_exp();
    e_ack = '0; e_err = '0; e_busy = 1'b0; e_brr = 1'b0;
    e_gid = IW'(m_grant); e_rd = m_rd; e_tcnt = m_tcnt;
  endtask

  function automatic int pick(input logic [NR-1:0] pat);
    for (int i = 1; i <= NR; i++) begin
      if (pat[(m_last + i) % NR]) return (m_last + i) % NR;
    end
    return m_last;
  endfunction

  task automatic idle_hold(input int n);
    bus.req = '0;
    set_idle_exp();
    for (int i = 0; i < n; i++) step();
  endtask

  // rise_at: REQ cycle where valid goes high (-1 never); stale: valid high on entry, low at REQ cycle 1.
  task automatic txn(input logic [NR-1:0] pat, input int rise_at, input bit stale,
                     input int drop_at, input int rst_at, input bit fixed, input logic [DW-1:0] fdata);
    logic          vv [TO];
    logic [DW-1:0] dat [TO];
    logic          vpre, pv;
    int            w, acc, last_k;
    w = pick(pat);
    vpre = stale;
    acc = -1;
    for (int k = 0; k < TO; k++) begin
      vv[k]  = (stale && k < 1) || (rise_at >= 0 && k >= rise_at);
      dat[k] = fixed ? fdata : DW'($urandom);
    end
    for (int k = 0; k < TO; k++) begin
      pv = (k == 0) ? vpre : vv[k-1];
      if (acc < 0 && vv[k] && !pv) acc = k;
    end
    last_k = (acc >= 0) ? acc : TO - 1;

    bus.req = pat; bus.buf_data_valid = vpre; bus.buf_data_in = DW'($urandom);
    set_idle_exp();
    t_req = cyc;
    step();
    m_grant = w;
    for (int k = 0; k <= last_k; k++) begin
      bus.req = (drop_at >= 0 && k >= drop_at) ? '0 : pat;
      bus.buf_data_valid = vv[k];
      bus.buf_data_in = dat[k];
      e_ack = '0; e_err = '0; e_busy = 1'b1; e_brr = 1'b1; e_gid = IW'(w);
      if (k == rst_at) aresetn = 1'b0;
      step();
      if (k == rst_at) begin
        aresetn = 1'b1;
        model_reset();
        bus.req = '0; bus.buf_data_valid = 1'b0;
        set_idle_exp();
        step();
        return;
      end
    end
    m_last = w;
    e_ack = '0; e_err = '0;
    if (acc >= 0) begin
      e_ack = NR'(1) << w;
      m_rd = dat[acc];
    end else begin
      e_err = NR'(1) << w;
      if (m_tcnt != 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
    end
    e_brr = 1'b0; e_busy = 1'b1; e_rd = m_rd; e_tcnt = m_tcnt;
    step();
    for (int g = 1; g < GP; g++) begin
      e_ack = '0; e_err = '0;
      step();
    end
    set_idle_exp();
  endtask

  initial begin
    int a0, e0;
    bus.req = '0; bus.buf_data_valid = 1'b0; bus.buf_data_in = '0;
    n_ack = 0; n_err = 0; t_brr = 0; t_ack = 0; t_err = 0; t_req = 0; last_ack = '0;
    model_reset();
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    set_idle_exp();
    step();
    step();
    aresetn = 1'b1;
    idle_hold(2);

    // Latency with a zero-wait buffer.
    txn(3'b001, 1, 1'b0, -1, -1, 1'b1, 25'h0123456);
    check("latency_req_to_brr", 32'(t_brr - t_req), 32'd1);
    check("latency_req_to_ack", 32'(t_ack - t_req), 32'd3);

    // Single requester 1, valid two cycles after request.
    a0 = n_ack;
    txn(3'b010, 2, 1'b0, -1, -1, 1'b1, 25'h1ABCDEF);
    check("single_ack_count", 32'(n_ack - a0), 32'd1);
    check("single_ack_vec", 32'(last_ack), 32'h2);
    check("single_rd_data", 32'(bus.rd_data), 32'h1ABCDEF);
    check("single_grant", 32'(bus.grant_id), 32'd1);
    check("single_ack_delay", 32'(t_ack - t_brr), 32'd3);

    // Empty buffer.
    e0 = n_err;
    txn(3'b100, -1, 1'b0, -1, -1, 1'b0, '0);
    check("timeout_err_count", 32'(n_err - e0), 32'd1);
    check("timeout_delay", 32'(t_err - t_brr), 32'd16);
    check("timeout_cnt_one", 32'(bus.timeout_cnt), 32'd1);
    check("timeout_rd_hold", 32'(bus.rd_data), 32'h1ABCDEF);
    idle_hold(1);

    // Edge on the last wait cycle.
    a0 = n_ack; e0 = n_err;
    txn(3'b001, 15, 1'b0, -1, -1, 1'b1, 25'h0F0F0F0);
    check("last_cycle_ack", 32'(n_ack - a0), 32'd1);
    check("last_cycle_no_err", 32'(n_err - e0), 32'd0);
    check("last_cycle_tcnt", 32'(bus.timeout_cnt), 32'd1);

    // Stale valid, then a genuine edge three cycles after it drops.
    a0 = n_ack;
    txn(3'b010, 4, 1'b1, 2, -1, 1'b1, 25'h0AAAA55);
    check("stale_ack_count", 32'(n_ack - a0), 32'd1);
    check("stale_rd_data", 32'(bus.rd_data), 32'h0AAAA55);

    // Reset in the middle of a wait.
    a0 = n_ack; e0 = n_err;
    txn(3'b100, 8, 1'b0, -1, 3, 1'b0, '0);
    check("reset_no_ack", 32'(n_ack - a0), 32'd0);
    check("reset_no_err", 32'(n_err - e0), 32'd0);
    check("reset_tcnt", 32'(bus.timeout_cnt), 32'd0);

    // Round robin from reset with everyone requesting.
    glog.delete();
    for (int t = 0; t < 9; t++) txn(3'b111, $urandom_range(0, 5), 1'b0, -1, -1, 1'b0, '0);
    check("rr_len", 32'(glog.size()), 32'd9);
    for (int t = 0; t < 9 && t < glog.size(); t++) check("rr_order", 32'(glog[t]), 32'(t % 3));

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      logic [NR-1:0] pat;
      int ra, da, rs;
      pat = NR'($urandom_range(1, 7));
      ra  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      da  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      rs  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 5)) : -1;
      txn(pat, ra, ($urandom_range(0, 3) == 0), da, rs, 1'b0, '0);
      idle_hold($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish by then", $time);
    $fatal(1);
  end
endmodule

// File: doc/buf_rd_arbiter.md
BUF_RD_ARBITER -- requirements
Module: buf_rd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of CPU-side requesters (2..8).
REQ-002 Parameter DATA_W, default 25: width of a tagged buffer word.
REQ-003 Parameter TIMEOUT, default 16: max cycles to wait for buffer data (4..255).
REQ-004 Parameter GAP, default 2: idle cycles with buf_read_request low between transactions (>=1).
REQ-005 aclk  input  1  clock; all logic SHALL be on the rising edge.
REQ-006 aresetn  input  1  reset, synchronous, active-low.
REQ-007 req  input  NUM_REQ  level read request per requester; held until ack or err.
REQ-008 ack  output  NUM_REQ  one-hot, one-cycle pulse; rd_data valid for the addressed requester.
REQ-009 err  output  NUM_REQ  one-hot, one-cycle pulse; timeout, no data for the addressed requester.
REQ-010 rd_data  output  DATA_W  shared data return, registered.
REQ-011 grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 buf_read_request  output  1  read request to the ultrasonic buffer.
REQ-014 buf_data_valid  input  1  buffer data-valid level; it may remain high between reads.
REQ-015 buf_data_in  input  DATA_W  buffer tagged data {sample, momentary, order, sending}.
REQ-016 timeout_cnt  output  16  saturating count of timed-out transactions.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, GAP; all outputs SHALL be registered.
REQ-018 IDLE, any req bit high: winner SHALL be the first set bit searching upward, with wrap-around, from last_grant+1. Next cycle: state=REQ, buf_read_request=1, grant_id=winner, wait counter=0.
REQ-019 IDLE, req all zero: state, outputs and pointer SHALL hold.
REQ-020 Edge detect: a register SHALL hold the previous buf_data_valid. Data SHALL be accepted only on a rising edge (valid=1, previous=0) observed in REQ. A level already high on REQ entry SHALL be ignored.
REQ-021 REQ, rising edge seen: on that clock edge, rd_data<=buf_data_in, ack[winner]<=1, buf_read_request<=0, state<=GAP, last_grant<=winner.
REQ-022 REQ, no edge: the counter SHALL increment each cycle.
REQ-023 REQ, counter==TIMEOUT-1 with no edge: err[winner]<=1, buf_read_request<=0, timeout_cnt+=1 (saturate at 16'hFFFF), rd_data SHALL hold, state<=GAP, last_grant<=winner.
REQ-024 REQ, edge and timeout in the same cycle: ack SHALL win; err SHALL NOT pulse.
REQ-025 ack and err SHALL be high exactly one cycle (the first GAP cycle) and never simultaneously.
REQ-026 GAP SHALL last exactly GAP cycles with buf_read_request=0, then go to IDLE. req SHALL be ignored during GAP.
REQ-027 Latency, with zero-wait buffer: req high at cycle 0, buf_read_request at 1, earliest ack at 3.
REQ-028 req[winner] dropping during REQ SHALL NOT abort the transaction; ack/err SHALL still be issued.
REQ-029 Fairness: with all requesters continuously asserting, grants SHALL rotate 0,1,..,NUM_REQ-1,0 with no requester skipped.

Reset
REQ-030 aresetn=0 at a clock edge SHALL force, on that edge: state=IDLE, ack=0, err=0, rd_data=0, grant_id=0, busy=0, buf_read_request=0, timeout_cnt=0, counter=0, previous-valid=0, last_grant=NUM_REQ-1 (first grant goes to requester 0).
REQ-031 Reset asserted in REQ or GAP SHALL abort the transaction with no ack/err pulse; after release, normal arbitration SHALL resume from IDLE.

Verification
REQ-032 Single requester: req=3'b010, buffer raises valid 2 cycles after request with data 25'h1ABCDEF -> ack=3'b010 one cycle, rd_data=25'h1ABCDEF, grant_id=1.
REQ-033 Round-robin: req=3'b111 held for 9 transactions -> grant order 0,1,2,0,1,2,0,1,2, GAP=2 cycles low between each.
REQ-034 Empty buffer: valid never rises, TIMEOUT=16 -> err pulses 16 cycles after the first REQ cycle, timeout_cnt=1, rd_data unchanged.
REQ-035 Stale valid: valid held high from the previous read entering REQ, drops, rises 3 cycles later -> exactly one ack, carrying data at the rising edge.
REQ-036 Edge on the last counter cycle: valid rises at counter==15 -> ack only, timeout_cnt unchanged.
REQ-037 Mid-transaction reset: aresetn low for 1 cycle during REQ -> all outputs reset, no ack/err, next grant goes to requester 0.
